// File: rtl/kbd_pkg.sv
// Shared constants, state type and command ROM for the PS/2 keyboard bring-up sequencer.
package kbd_pkg;

    localparam logic [7:0] KBD_CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] KBD_CMD_SCANSET = 8'hF0;
    localparam logic [7:0] KBD_SCANSET_1   = 8'h01;
    localparam logic [7:0] KBD_ACK         = 8'hFA;
    localparam logic [7:0] KBD_RESEND      = 8'hFE;
    localparam logic [7:0] KBD_BAT_OK      = 8'hAA;

    typedef enum logic [2:0] {
        ST_BOOT  = 3'd0,
        ST_SEND  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RUN   = 3'd3,
        ST_ERROR = 3'd4
    } kbd_seq_state_t;

    function automatic logic [7:0] kbd_cmd_rom(input logic [1:0] idx);
        case (idx)
            2'd0:    return KBD_CMD_ENABLE;
            2'd1:    return KBD_CMD_SCANSET;
            default: return KBD_SCANSET_1;
        endcase
    endfunction

endpackage

// File: rtl/kbd_ack_timer.sv
// Saturating acknowledge timeout counter; expired holds once ACK_TIMEOUT cycles have been counted.
module kbd_ack_timer #(
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int TW = $clog2(ACK_TIMEOUT);
    localparam logic [TW-1:0] LAST = TW'(ACK_TIMEOUT - 1);

    logic [TW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (enable && cnt != LAST)
            cnt <= cnt + 1'b1;
    end

    assign expired = (cnt == LAST);

endmodule

// File: rtl/kbd_init_sequencer.sv
// PS/2 keyboard bring-up: sends F4, F0, 01 with ack/resend/timeout retries, then forwards scan codes.
module kbd_init_sequencer
    import kbd_pkg::*;
#(
    parameter int ACK_TIMEOUT = 1024,
    parameter int MAX_RETRY   = 3
) (
    input  logic       KBD_CLK,
    input  logic       KBD_RESET,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       reinit,
    output logic [7:0] scan_data,
    output logic       scan_valid,
    output logic       init_done,
    output logic       init_error
);
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

    kbd_seq_state_t state_q, state_d;
    logic [1:0]     step_q, step_d;
    logic [RW-1:0]  retry_q, retry_d;
    logic           booted_q;
    logic           fwd;
    logic           expired;

    // Timer runs only in WAIT; holding it clear elsewhere makes every WAIT entry start from zero.
    kbd_ack_timer #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_ack_timer (
        .clk    (KBD_CLK),
        .rst    (KBD_RESET),
        .clear  (state_q != ST_WAIT),
        .enable (state_q == ST_WAIT),
        .expired(expired)
    );

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        retry_d = retry_q;
        fwd     = 1'b0;
        unique case (state_q)
            ST_BOOT: begin
                if (booted_q) begin
                    state_d = ST_SEND;
                    step_d  = '0;
                    retry_d = '0;
                end
            end
            ST_SEND: begin
                if (tx_valid && tx_ready)
                    state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A received byte always outranks a coincident timeout.
                if (rx_valid && rx_data == KBD_ACK) begin
                    if (step_q == 2'd2) begin
                        state_d = ST_RUN;
                    end else begin
                        step_d  = step_q + 2'd1;
                        retry_d = '0;
                        state_d = ST_SEND;
                    end
                end else if ((rx_valid && rx_data == KBD_RESEND) || (!rx_valid && expired)) begin
                    if (retry_q == RETRY_LIMIT) begin
                        state_d = ST_ERROR;
                    end else begin
                        retry_d = retry_q + 1'b1;
                        state_d = ST_SEND;
                    end
                end
            end
            ST_RUN: begin
                if (rx_valid) begin
                    if (rx_data == KBD_BAT_OK) begin
                        state_d = ST_SEND;
                        step_d  = '0;
                        retry_d = '0;
                    end else begin
                        fwd = 1'b1;
                    end
                end
            end
            ST_ERROR: ;
            default: state_d = ST_BOOT;
        endcase
        if (reinit && state_q != ST_BOOT) begin
            state_d = ST_SEND;
            step_d  = '0;
            retry_d = '0;
            fwd     = 1'b0;
        end
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge KBD_CLK or posedge KBD_RESET) begin
        if (KBD_RESET) begin
            state_q    <= ST_BOOT;
            step_q     <= '0;
            retry_q    <= '0;
            booted_q   <= 1'b0;
            tx_valid   <= 1'b0;
            tx_data    <= '0;
            scan_valid <= 1'b0;
            scan_data  <= '0;
            init_done  <= 1'b0;
            init_error <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            retry_q    <= retry_d;
            booted_q   <= 1'b1;
            tx_valid   <= (state_d == ST_SEND);
            if (state_d == ST_SEND)
                tx_data <= kbd_cmd_rom(step_d);
            scan_valid <= fwd;
            if (fwd)
                scan_data <= rx_data;
            init_done  <= (state_d == ST_RUN);
            init_error <= (state_d == ST_ERROR);
        end
    end

endmodule

// File: tb/tb_kbd_init_sequencer.sv
// Bench for kbd_init_sequencer: directed bring-up/corner sequences, a RUN vector table, and a randomized keyboard.
module tb_kbd_init_sequencer;

    logic       KBD_CLK;
    logic       KBD_RESET;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       reinit;
    logic [7:0] scan_data;
    logic       scan_valid;
    logic       init_done;
    logic       init_error;

    localparam int TMO  = 16;
    localparam int MAXR = 3;

    kbd_init_sequencer #(.ACK_TIMEOUT(TMO), .MAX_RETRY(MAXR)) dut (
        .KBD_CLK   (KBD_CLK),
        .KBD_RESET (KBD_RESET),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .reinit    (reinit),
        .scan_data (scan_data),
        .scan_valid(scan_valid),
        .init_done (init_done),
        .init_error(init_error)
    );

    initial KBD_CLK = 1'b0;
    always #5 KBD_CLK = ~KBD_CLK;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rv;
        logic [7:0] rd;
        logic       exp_sv;
        logic [7:0] exp_sd;
        logic       exp_done;
        logic       exp_txv;
    } vec_t;
    vec_t vecs[5];

    logic [7:0] cmd[3];
    int         waited;
    int         step, fails, outcome;
    int         r;
    logic [7:0] b, last_fwd;
    logic       rv;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge KBD_CLK);
        #1;
    endtask

    task automatic reset_dut();
        KBD_RESET = 1'b1;
        tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; reinit = 1'b0;
        tick(); tick();
        chk("rst_outs", {tx_valid, tx_data, scan_valid, scan_data, init_done, init_error}, 0);
        KBD_RESET = 1'b0;
        tick();
        chk("boot_edge1_txv", tx_valid, 0);
        tick();
        chk("boot_edge2_txv", tx_valid, 1);
        chk("boot_edge2_txd", tx_data, 8'hF4);
    endtask

    // Wait (bounded) for a command byte, check it, then complete the handshake.
    task automatic xmit(input logic [7:0] exp, input string nm, input bit stall, output int w);
        w = 0;
        while (!tx_valid && w < 60) begin tick(); w++; end
        chk({nm, "_txv"}, tx_valid, 1);
        chk({nm, "_txd"}, tx_data, exp);
        if (stall) begin
            tx_ready = 1'b0;
            repeat ($urandom_range(0, 3)) tick();
        end
        tx_ready = 1'b1;
        tick();
        chk({nm, "_drop"}, tx_valid, 0);
    endtask

    task automatic reply(input logic [7:0] v, input int d);
        repeat (d) tick();
        rx_data = v; rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic pulse_reinit();
        reinit = 1'b1;
        tick();
        reinit = 1'b0;
    endtask

    task automatic wait_event();
        int n = 0;
        while (!(tx_valid || init_done || init_error) && n < 60) begin tick(); n++; end
        chk("evt_bound", (n < 60), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        cmd[0] = 8'hF4; cmd[1] = 8'hF0; cmd[2] = 8'h01;
        vecs[0] = '{1'b1, 8'h1C, 1'b1, 8'h1C, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 8'hF0, 1'b1, 8'hF0, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 8'h1C, 1'b1, 8'h1C, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 8'h00, 1'b0, 8'h1C, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 8'hAA, 1'b0, 8'h1C, 1'b0, 1'b1};

        reset_dut();

        // Nominal bring-up, FA three cycles after each handshake.
        xmit(8'hF4, "nom_f4", 1'b0, waited); reply(8'hFA, 2);
        xmit(8'hF0, "nom_f0", 1'b0, waited); chk("nom_lat_f0", waited, 0); reply(8'hFA, 2);
        xmit(8'h01, "nom_01", 1'b0, waited); chk("nom_lat_01", waited, 0); reply(8'hFA, 2);
        chk("nom_done", init_done, 1);
        chk("nom_err", init_error, 0);
        chk("nom_txv", tx_valid, 0);

        // RUN forwarding, back-to-back strobes, hold, then hot-plug AA.
        for (int i = 0; i < 5; i++) begin
            rx_valid = vecs[i].rv; rx_data = vecs[i].rd;
            tick();
            rx_valid = 1'b0;
            chk($sformatf("vec%0d_sv", i), scan_valid, vecs[i].exp_sv);
            chk($sformatf("vec%0d_sd", i), scan_data, vecs[i].exp_sd);
            chk($sformatf("vec%0d_done", i), init_done, vecs[i].exp_done);
            chk($sformatf("vec%0d_txv", i), tx_valid, vecs[i].exp_txv);
        end
        chk("hp_txd", tx_data, 8'hF4);

        // Resend on F0, then three resends on 01 still fit in the retry budget.
        xmit(8'hF4, "rs_f4", 1'b0, waited); reply(8'hFA, 2);
        xmit(8'hF0, "rs_f0a", 1'b0, waited); reply(8'hFE, 2);
        xmit(8'hF0, "rs_f0b", 1'b0, waited); chk("rs_lat", waited, 0); reply(8'hFA, 2);
        for (int i = 0; i < 3; i++) begin
            xmit(8'h01, "rs_01", 1'b0, waited); reply(8'hFE, 1);
        end
        xmit(8'h01, "rs_01last", 1'b0, waited); reply(8'hFA, 2);
        chk("rs_done", init_done, 1);
        chk("rs_err", init_error, 0);

        // Timeout exhaustion: four F4 attempts, each retry 16 WAIT cycles after its handshake.
        pulse_reinit();
        chk("to_restart_txv", tx_valid, 1);
        for (int a = 0; a < 4; a++) begin
            xmit(8'hF4, "to_f4", 1'b0, waited);
            if (a > 0) chk("to_spacing", waited, TMO);
        end
        repeat (TMO - 1) tick();
        chk("to_err_early", init_error, 0);
        tick();
        chk("to_err", init_error, 1);
        chk("to_txv", tx_valid, 0);
        reply(8'hFA, 0);
        chk("to_err_inert", init_error, 1);
        chk("to_err_sv", scan_valid, 0);
        chk("to_err_txv", tx_valid, 0);
        pulse_reinit();
        chk("to_reinit_txv", tx_valid, 1);
        chk("to_reinit_txd", tx_data, 8'hF4);
        chk("to_reinit_err", init_error, 0);

        // FA arriving on the timeout edge advances instead of retrying.
        xmit(8'hF4, "pt_f4", 1'b0, waited);
        repeat (TMO - 1) tick();
        reply(8'hFA, 0);
        chk("pt_fa_txv", tx_valid, 1);
        chk("pt_fa_txd", tx_data, 8'hF0);

        // reinit beats a simultaneous FA.
        xmit(8'hF0, "pr_f0", 1'b0, waited);
        tick();
        rx_data = 8'hFA; rx_valid = 1'b1; reinit = 1'b1;
        tick();
        rx_valid = 1'b0; reinit = 1'b0;
        chk("pr_reinit_txv", tx_valid, 1);
        chk("pr_reinit_txd", tx_data, 8'hF4);

        // reinit coinciding with a SEND handshake keeps offering F4.
        pulse_reinit();
        chk("ph_txv", tx_valid, 1);
        chk("ph_txd", tx_data, 8'hF4);

        // Asynchronous reset in the middle of WAIT.
        xmit(8'hF4, "ar_f4", 1'b0, waited); reply(8'hFA, 2);
        xmit(8'hF0, "ar_f0", 1'b0, waited);
        tick(); tick();
        #2 KBD_RESET = 1'b1;
        #1 chk("ar_outs", {tx_valid, tx_data, scan_valid, scan_data, init_done, init_error}, 0);
        reset_dut();

        // Randomized keyboard responses against a transaction-level model.
        for (int round = 0; round < 10; round++) begin
            step = 0; fails = 0; outcome = 0;
            while (outcome == 0) begin
                xmit(cmd[step], "rnd_tx", 1'b1, waited);
                r = $urandom_range(0, 99);
                if (r < 50 || r >= 65 && r < 80) begin
                    if (r >= 65) begin
                        do b = 8'($urandom_range(0, 255)); while (b == 8'hFA || b == 8'hFE);
                        reply(b, $urandom_range(0, 4));
                        reply(8'hFA, $urandom_range(0, 4));
                    end else begin
                        reply(8'hFA, $urandom_range(0, 8));
                    end
                    if (step == 2) outcome = 1;
                    else begin step++; fails = 0; end
                end else begin
                    if (r < 65) reply(8'hFE, $urandom_range(0, 8));
                    if (fails == MAXR) outcome = 2;
                    else fails++;
                end
                wait_event();
                chk("rnd_done", init_done, outcome == 1);
                chk("rnd_err", init_error, outcome == 2);
                chk("rnd_txv", tx_valid, outcome == 0);
            end
            if (outcome == 1) begin
                last_fwd = scan_data;
                for (int i = 0; i < 24; i++) begin
                    rv = 1'($urandom_range(0, 1));
                    do b = 8'($urandom_range(0, 255)); while (b == 8'hAA);
                    rx_valid = rv; rx_data = b;
                    tick();
                    rx_valid = 1'b0;
                    if (rv) last_fwd = b;
                    chk("rnd_sv", scan_valid, rv);
                    chk("rnd_sd", scan_data, last_fwd);
                end
            end
            pulse_reinit();
            chk("rnd_reinit_txv", tx_valid, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
